mac_seq: RTL and testbench
==========================

// Module: mac_seq
// PURPOSE
//  Dot-product sequencer directly upstream of the mac block (DSP A*B+C with 20-bit psum feedback).
//  Accepts a job length, streams operand pairs from a valid/ready source onto mac i_a/i_b, and clears the accumulator.
//  Waits out the DSP/psum pipeline, captures the final o_mac and presents it on a valid/ready result port.
// PARAMETERS
//  DATA_W     8   operand width; operands are unsigned
//  ACC_W      20  accumulator/result width; must equal mac o_mac width
//  LEN_W      8   width of cfg_len (max 2^LEN_W-1 terms per job)
//  DRAIN_CYC  2   cycles from a term on mac_a/mac_b until mac_acc includes it
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       job request; sampled only in IDLE
//  cfg_len    in   LEN_W   number of terms; sampled with start
//  busy       out  1       high in every state except IDLE
//  s_valid    in   1       operand pair valid
//  s_ready    out  1       operand pair accepted when s_valid&s_ready
//  s_a        in   DATA_W  operand A
//  s_b        in   DATA_W  operand B
//  mac_a      out  DATA_W  to mac i_a (registered)
//  mac_b      out  DATA_W  to mac i_b (registered)
//  mac_sclr   out  1       to mac sclr (registered)
//  mac_acc    in   ACC_W   from mac o_mac
//  m_valid    out  1       result valid
//  m_ready    in   1       result consumed when m_valid&m_ready
//  m_result   out  ACC_W   captured accumulation
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state IDLE; busy=0, s_ready=0, m_valid=0, m_result=0, mac_a=0, mac_b=0, mac_sclr=1.
//    mac_sclr stays 1 every cycle rst is high, then drops to 0 the cycle after rst deasserts. Reset mid-job aborts it; no result.
//  - FSM: IDLE -> CLR -> RUN -> DRAIN -> OUT -> IDLE.
//  - IDLE: start=1 latches cfg_len into term counter -> CLR. start in any other state is ignored.
//  - CLR: exactly one cycle; mac_sclr=1 on the following cycle, mac_a/mac_b=0. len=0 -> DRAIN, else -> RUN.
//  - RUN: s_ready=1 (combinational from state). Each handshake registers s_a/s_b onto mac_a/mac_b next cycle and decrements the counter.
//    Cycles with no handshake drive mac_a=mac_b=0 next cycle (adds 0, psum unchanged); bubbles are legal and invisible in result.
//    Handshake on the last term -> DRAIN; s_ready=0 from the next cycle.
//  - DRAIN: wait counter loaded with DRAIN_CYC+1 on entry; on expiry capture mac_acc into m_result -> OUT.
//  - OUT: m_valid=1; m_result stable until m_valid&m_ready; then m_valid=0 -> IDLE. m_ready outside OUT has no effect.
//  - Arithmetic: result = sum(s_a*s_b) over job, unsigned, modulo 2^ACC_W (no saturation, no overflow flag).
//  - Throughput: one term per cycle in RUN; per-job overhead = 1 (CLR) + DRAIN_CYC+1 + 1 (OUT min) cycles.
//  - mac_sclr is high only in the CLR-follow cycle and during reset; never high while terms are in flight.
// STRUCTURE
//  - Shared package mac_pkg: DATA_W/ACC_W constants (shared with mac), FSM state encoding (IDLE,CLR,RUN,DRAIN,OUT).
//  - One sub-module: mac_seq_cnt, loadable down-counter with zero flag, reused for term count and drain wait.
//  - Everything else (FSM, operand/sclr registers, result register) inline.
// TESTING
//  1. len=4, a={1,2,3,4}, b={5,6,7,8}, s_valid always 1, m_ready=1 -> m_result=70, m_valid one cycle, mac_sclr one pulse.
//  2. len=3, a=b={255,255,255}, 2-cycle s_valid gaps -> m_result=195075; mac_a/mac_b=0 during gaps.
//  3. len=1 (7*9), m_ready=0 for 5 cycles, start pulsed during OUT -> m_result=63 held stable; start ignored; busy=1 throughout.
//  4. len=0 -> s_ready never asserted, m_result=0, m_valid after CLR + DRAIN_CYC+1 cycles.
//  5. rst for 2 cycles after 2 of 4 terms -> reset values, mac_sclr=1 during rst; next job len=1 (3*4) -> 12.
//  6. Back-to-back: len=2 (10*10, 10*10) -> 200, then len=1 (2*2) -> 4 (no carry-over).
//  Checker: scoreboard compares m_result to mod-2^ACC_W reference model; assert s_ready=0 outside RUN.

Source files
------------

// File: rtl/mac_pkg.sv
// Constants and FSM encoding shared by the mac datapath and its dot-product sequencer.
package mac_pkg;

  localparam int MAC_DATA_W    = 8;
  localparam int MAC_ACC_W     = 20;
  localparam int SEQ_LEN_W     = 8;
  localparam int SEQ_DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/mac_seq_cnt.sv
// Loadable down-counter; shared between the job term count and the pipeline drain wait.
module mac_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/mac_seq.sv
// Dot-product sequencer: clears the mac, streams operand pairs into it, waits out the
// DSP/psum pipeline and hands the final accumulation to a valid/ready result port.
module mac_seq
  import mac_pkg::*;
#(
  parameter int DATA_W    = MAC_DATA_W,
  parameter int ACC_W     = MAC_ACC_W,
  parameter int LEN_W     = SEQ_LEN_W,
  parameter int DRAIN_CYC = SEQ_DRAIN_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_a,
  input  logic [DATA_W-1:0] s_b,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_sclr,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_result
);

  // The drain counter expires on its last count, so DRAIN lasts exactly DRAIN_CYC+1 cycles.
  localparam logic [LEN_W-1:0] DRAIN_LOAD = LEN_W'(DRAIN_CYC + 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic             hs;
  logic             cnt_load;
  logic [LEN_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             cnt_last;
  logic             capture;

  assign s_ready = (state == ST_RUN);
  assign busy    = (state != ST_IDLE);
  assign m_valid = (state == ST_OUT);
  assign hs      = s_valid && s_ready;

  mac_seq_cnt #(
    .W(LEN_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_load  = 1'b1;
          cnt_val   = cfg_len;
          state_nxt = ST_CLR;
        end
      end
      ST_CLR: begin
        if (cnt_zero) begin
          cnt_load  = 1'b1;
          cnt_val   = DRAIN_LOAD;
          state_nxt = ST_DRAIN;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (hs) begin
          if (cnt_last) begin
            cnt_load  = 1'b1;
            cnt_val   = DRAIN_LOAD;
            state_nxt = ST_DRAIN;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_last) begin
          capture   = 1'b1;
          state_nxt = ST_OUT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Non-handshake cycles feed zeros, so bubbles add nothing to the running psum.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_a    <= '0;
      mac_b    <= '0;
      mac_sclr <= 1'b1;
      m_result <= '0;
    end else begin
      mac_a    <= hs ? s_a : '0;
      mac_b    <= hs ? s_b : '0;
      mac_sclr <= (state == ST_CLR);
      if (capture) begin
        m_result <= mac_acc;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq with a behavioural 2-stage mac model and a sum-of-products scoreboard.
module tb_mac_seq;
  import mac_pkg::*;

  localparam int DW = MAC_DATA_W;
  localparam int AW = MAC_ACC_W;
  localparam int LW = SEQ_LEN_W;
  localparam int DRAIN = SEQ_DRAIN_CYC;

  typedef struct packed {
    logic [7:0]             len;
    logic [31:0][DW-1:0]    a;
    logic [31:0][DW-1:0]    b;
    logic [1:0]             gap;
    logic [3:0]             hold;
    logic                   pulse_start;
    logic [AW-1:0]          exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] cfg_len;
  logic          busy;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_a;
  logic [DW-1:0] s_b;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic          mac_sclr;
  logic [AW-1:0] mac_acc;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_result;

  logic [2*DW-1:0] prod;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sclr_cnt = 0;
  int sready_cnt = 0;
  logic [AW-1:0] exp_q[$];
  vec_t tbl[7];

  mac_seq dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_sclr(mac_sclr), .mac_acc(mac_acc),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream mac: product register then accumulate, so a term shows in mac_acc two cycles later.
  always @(posedge clk) begin
    if (mac_sclr) begin
      prod    <= '0;
      mac_acc <= '0;
    end else begin
      prod    <= mac_a * mac_b;
      mac_acc <= mac_acc + AW'(prod);
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mac_sclr) sclr_cnt++;
      if (s_ready) sready_cnt++;
      if (!busy || m_valid) check_output("s_ready_outside_run", 32'(s_ready), 32'd0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result actual=%0d required=none", m_result);
        end else begin
          check_output("m_result", 32'(m_result), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  function automatic logic [AW-1:0] ref_dot(input vec_t v);
    longint sum = 0;
    for (int i = 0; i < int'(v.len); i++) sum = sum + longint'(v.a[i]) * longint'(v.b[i]);
    return AW'(sum % (longint'(1) << AW));
  endfunction

  task automatic feed_term(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int w = 0;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    while (!s_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) check_output("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    check_output("mac_a_term", 32'(mac_a), 32'(a));
    check_output("mac_b_term", 32'(mac_b), 32'(b));
  endtask

  task automatic apply_stimulus(input vec_t v);
    int w;
    int start_cyc;
    logic [AW-1:0] held;
    exp_q.push_back(v.exp);
    sclr_cnt = 0;
    sready_cnt = 0;
    m_ready = (v.hold == 0);
    start = 1'b1;
    cfg_len = v.len;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_len = LW'($urandom);
    start_cyc = cyc;
    for (int i = 0; i < int'(v.len); i++) begin
      for (int g = 0; g < int'(v.gap); g++) begin
        s_valid = 1'b0;
        s_a = DW'($urandom);
        s_b = DW'($urandom);
        @(posedge clk); #1;
        check_output("mac_a_bubble", 32'(mac_a), 32'd0);
        check_output("mac_b_bubble", 32'(mac_b), 32'd0);
      end
      feed_term(v.a[i], v.b[i]);
    end
    s_valid = 1'b0;
    w = 0;
    while (!m_valid && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    check_output("m_valid_arrives", 32'(m_valid), 32'd1);
    if (v.gap == 0) begin
      check_output("result_latency", 32'(cyc - start_cyc), 32'(int'(v.len) + DRAIN + 2));
      check_output("s_ready_cycles", 32'(sready_cnt), 32'(v.len));
    end
    held = m_result;
    for (int h = 0; h < int'(v.hold); h++) begin
      if (v.pulse_start) begin
        start = 1'b1;
        cfg_len = LW'(1);
      end
      @(posedge clk); #1;
      start = 1'b0;
      check_output("m_valid_held", 32'(m_valid), 32'd1);
      check_output("busy_held", 32'(busy), 32'd1);
      check_output("m_result_stable", 32'(m_result), 32'(held));
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check_output("m_valid_drop", 32'(m_valid), 32'd0);
    check_output("busy_drop", 32'(busy), 32'd0);
    check_output("sclr_pulses", 32'(sclr_cnt), 32'd1);
  endtask

  task automatic check_reset_values(input logic [DW-1:0] dummy);
    check_output("rst_busy", 32'(busy), 32'(dummy));
    check_output("rst_s_ready", 32'(s_ready), 32'd0);
    check_output("rst_m_valid", 32'(m_valid), 32'd0);
    check_output("rst_m_result", 32'(m_result), 32'd0);
    check_output("rst_mac_a", 32'(mac_a), 32'd0);
    check_output("rst_mac_b", 32'(mac_b), 32'd0);
    check_output("rst_mac_sclr", 32'(mac_sclr), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    rst = 1'b1;
    start = 1'b0;
    cfg_len = '0;
    s_valid = 1'b0;
    s_a = '0;
    s_b = '0;
    m_ready = 1'b1;

    for (int k = 0; k < 7; k++) tbl[k] = '0;
    tbl[0].len = 8'd4;
    for (int i = 0; i < 4; i++) begin
      tbl[0].a[i] = DW'(i + 1);
      tbl[0].b[i] = DW'(i + 5);
    end
    tbl[0].exp = AW'(70);
    tbl[1].len = 8'd3; tbl[1].gap = 2'd2; tbl[1].exp = AW'(195075);
    for (int i = 0; i < 3; i++) begin
      tbl[1].a[i] = 8'd255;
      tbl[1].b[i] = 8'd255;
    end
    tbl[2].len = 8'd1; tbl[2].a[0] = 8'd7; tbl[2].b[0] = 8'd9;
    tbl[2].hold = 4'd5; tbl[2].pulse_start = 1'b1; tbl[2].exp = AW'(63);
    tbl[3].len = 8'd0; tbl[3].exp = AW'(0);
    tbl[4].len = 8'd2; tbl[4].exp = AW'(200);
    for (int i = 0; i < 2; i++) begin
      tbl[4].a[i] = 8'd10;
      tbl[4].b[i] = 8'd10;
    end
    tbl[5].len = 8'd1; tbl[5].a[0] = 8'd2; tbl[5].b[0] = 8'd2; tbl[5].exp = AW'(4);
    tbl[6].len = 8'd20; tbl[6].exp = AW'(251924);
    for (int i = 0; i < 20; i++) begin
      tbl[6].a[i] = 8'd255;
      tbl[6].b[i] = 8'd255;
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_values('0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("sclr_after_rst", 32'(mac_sclr), 32'd0);

    for (int k = 0; k < 4; k++) apply_stimulus(tbl[k]);

    // Abort a 4-term job after two terms; reset must discard it and no result may appear.
    start = 1'b1;
    cfg_len = LW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    feed_term(8'd3, 8'd3);
    feed_term(8'd5, 8'd5);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values('0);
    @(posedge clk); #1;
    check_reset_values('0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_output("sclr_after_abort", 32'(mac_sclr), 32'd0);
    check_output("busy_after_abort", 32'(busy), 32'd0);
    v = '0;
    v.len = 8'd1; v.a[0] = 8'd3; v.b[0] = 8'd4; v.exp = AW'(12);
    apply_stimulus(v);

    for (int k = 4; k < 7; k++) apply_stimulus(tbl[k]);

    for (int r = 0; r < 16; r++) begin
      v = '0;
      v.len = 8'($urandom_range(0, 32));
      for (int i = 0; i < 32; i++) begin
        v.a[i] = DW'($urandom);
        v.b[i] = DW'($urandom);
      end
      v.gap = 2'($urandom_range(0, 2));
      v.hold = 4'($urandom_range(0, 3));
      v.pulse_start = 1'($urandom_range(0, 1));
      v.exp = ref_dot(v);
      apply_stimulus(v);
    end

    repeat (3) @(posedge clk);
    #1;
    check_output("results_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
